// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one combinational ALU among NUM_REQ requesters. Requests are picked
// round-robin, the winner's opcode and operands are registered onto the ALU
// inputs, and the ALU result is registered on its way back. Only one
// transaction is in flight at a time. Each transaction moves IDLE -> EXEC ->
// RESP and takes at least 3 cycles.
//
// Ports
//   clk, rst        rising-edge clock, synchronous active-high reset
//   req_valid/ready per-requester request handshake (ready is one-hot or zero)
//   req_op/in1/in2  flattened request fields, requester i at [i*W +: W]
//   resp_valid      per-requester result valid (one-hot or zero)
//   resp_ready      per-requester result accept; only the granted bit matters
//   resp_data/err   shared result bus; err flags the illegal opcode 7
//   alu_op/in1/in2  registered ALU inputs
//   alu_out         combinational ALU result
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3,
  parameter int NUM_REQ    = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_in1,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_in2,
  output logic [NUM_REQ-1:0]             resp_valid,
  input  logic [NUM_REQ-1:0]             resp_ready,
  output logic [DATA_WIDTH-1:0]          resp_data,
  output logic                           resp_err,
  output logic [OP_WIDTH-1:0]            alu_op,
  output logic [DATA_WIDTH-1:0]          alu_in1,
  output logic [DATA_WIDTH-1:0]          alu_in2,
  input  logic [DATA_WIDTH-1:0]          alu_out
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [OP_WIDTH-1:0] OP_ILLEGAL = OP_WIDTH'(7);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         grant;
  logic [PTR_W-1:0]         winner;
  logic                     found;
  logic [2*NUM_REQ-1:0]     valid_rot;
  logic [NUM_REQ-1:0]       winner_oh;
  logic [NUM_REQ-1:0]       grant_oh;
  logic [OP_WIDTH-1:0]      sel_op;
  logic [DATA_WIDTH-1:0]    sel_in1;
  logic [DATA_WIDTH-1:0]    sel_in2;

  // (base + off) mod NUM_REQ for off < NUM_REQ, without a divider.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    logic [PTR_W:0] sum;
    sum = {1'b0, base} + (PTR_W+1)'(off);
    if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
    return sum[PTR_W-1:0];
  endfunction

  // Rotating two copies of req_valid right by rr_ptr puts the search order
  // (rr_ptr, rr_ptr+1, ... wrapping) into bits 0..NUM_REQ-1.
  assign valid_rot = {req_valid, req_valid} >> rr_ptr;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && valid_rot[k]) begin
        found  = 1'b1;
        winner = wrap_add(rr_ptr, unsigned'(k));
      end
    end
  end

  always_comb begin
    sel_op  = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        sel_op  = req_op [i*OP_WIDTH   +: OP_WIDTH];
        sel_in1 = req_in1[i*DATA_WIDTH +: DATA_WIDTH];
        sel_in2 = req_in2[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign winner_oh = NUM_REQ'(1) << winner;
  assign grant_oh  = NUM_REQ'(1) << grant;

  // Handshake outputs are gated by rst so they drop in the reset cycle itself.
  assign req_ready  = (!rst && state == IDLE && found) ? winner_oh : '0;
  assign resp_valid = (!rst && state == RESP)          ? grant_oh  : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      // NOTE: the datapath registers are reset too, because every output
      // must read zero after reset, not just the control state.
      alu_op    <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them
      // update together from the values present before the edge.
      case (state)
        IDLE: begin
          if (found) begin
            grant   <= winner;
            alu_op  <= sel_op;
            alu_in1 <= sel_in1;
            alu_in2 <= sel_in2;
            state   <= EXEC;
          end
        end
        EXEC: begin
          if (alu_op == OP_ILLEGAL) begin
            resp_data <= '0;
            resp_err  <= 1'b1;
          end else begin
            resp_data <= alu_out;
            resp_err  <= 1'b0;
          end
          state <= RESP;
        end
        RESP: begin
          if (|(resp_ready & grant_oh)) begin
            rr_ptr <= wrap_add(grant, 1);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
